// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Groups the two requester ports (instruction fetch, load/store), the shared
// memory bus and the stall request of the memory arbiter.
//   slave  : view taken by the arbiter (requests in, bus out)
//   master : view taken by the requesters / memory model / testbench
// Signals:
//   if_req_i/if_addr_i            fetch request, byte address
//   if_rdata_o/if_ack_o           fetch data, one-cycle completion
//   mem_req_i/mem_we_i/mem_addr_i/mem_wdata_i/mem_sel_i  load/store request
//   mem_rdata_o/mem_ack_o         load data, one-cycle completion
//   bus_ce_o/bus_we_o/bus_addr_o/bus_wdata_o/bus_sel_o   shared memory cycle
//   bus_rdata_i/bus_ack_i         shared memory read data, completion
//   err_o                         pulse with an ack produced by timeout
//   stallreq_o                    pipeline stall request
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ack_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_rdata_o;
   logic        mem_ack_o;
   logic        bus_ce_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        err_o;
   logic        stallreq_o;

   modport slave (
      input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i,
             mem_wdata_i, mem_sel_i, bus_rdata_i, bus_ack_i,
      output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_ce_o,
             bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, err_o, stallreq_o
   );

   modport master (
      output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i,
             mem_wdata_i, mem_sel_i, bus_rdata_i, bus_ack_i,
      input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_ce_o,
             bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, err_o, stallreq_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a load/store port onto a single
// shared memory bus. Load/store has fixed priority. One transfer at a time;
// a transfer without bus_ack_i for TIMEOUT cycles is aborted with err_o.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   arb  : mem_arbiter_if.slave (requesters, shared bus, err, stall request)
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave arb
);
   localparam logic [3:0] TO = TIMEOUT[3:0];

   typedef enum logic [1:0] {IDLE, IF_XFER, MEM_XFER} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic        if_ack_q, mem_ack_q, err_q;
   logic [31:0] if_rdata_q, mem_rdata_q;
   logic        if_go, mem_go, done;

   // A request seen in the cycle of its own ack is the one just served.
   assign if_go  = arb.if_req_i  & ~if_ack_q;
   assign mem_go = arb.mem_req_i & ~mem_ack_q;
   assign cnt_d  = cnt_q + 4'd1;
   assign done   = arb.bus_ack_i | (cnt_d == TO);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         err_q       <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         // Completion outputs are single-cycle pulses; rdata is zero off-ack.
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         err_q       <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (mem_go) begin
                  state_q <= MEM_XFER;
                  addr_q  <= arb.mem_addr_i;
                  we_q    <= arb.mem_we_i;
                  wdata_q <= arb.mem_wdata_i;
                  sel_q   <= arb.mem_sel_i;
               end else if (if_go) begin
                  state_q <= IF_XFER;
                  addr_q  <= arb.if_addr_i;
                  we_q    <= 1'b0;
                  wdata_q <= '0;
                  sel_q   <= 4'b1111;
               end
            end
            IF_XFER, MEM_XFER: begin
               if (done) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  // A real ack wins over a timeout reached in the same cycle.
                  err_q   <= ~arb.bus_ack_i;
                  if (state_q == IF_XFER) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= arb.bus_ack_i ? arb.bus_rdata_i : '0;
                  end else begin
                     mem_ack_q   <= 1'b1;
                     mem_rdata_q <= (arb.bus_ack_i && !we_q) ? arb.bus_rdata_i : '0;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign arb.bus_ce_o    = (state_q != IDLE);
   assign arb.bus_we_o    = we_q;
   assign arb.bus_addr_o  = addr_q;
   assign arb.bus_wdata_o = wdata_q;
   assign arb.bus_sel_o   = sel_q;
   assign arb.if_ack_o    = if_ack_q;
   assign arb.if_rdata_o  = if_rdata_q;
   assign arb.mem_ack_o   = mem_ack_q;
   assign arb.mem_rdata_o = mem_rdata_q;
   assign arb.err_o       = err_q;
   assign arb.stallreq_o  = (arb.if_req_i & ~if_ack_q) | (arb.mem_req_i & ~mem_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   mem_arbiter_if arb_if();
   mem_arbiter #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .arb(arb_if));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Sample 1 time unit after the rising edge; inputs change at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      arb_if.if_req_i    = 0;
      arb_if.if_addr_i   = 0;
      arb_if.mem_req_i   = 0;
      arb_if.mem_we_i    = 0;
      arb_if.mem_addr_i  = 0;
      arb_if.mem_wdata_i = 0;
      arb_if.mem_sel_i   = 0;
      arb_if.bus_rdata_i = 0;
      arb_if.bus_ack_i   = 0;

      // Reset state
      tick();
      chk("rst_ce", 32'(arb_if.bus_ce_o), 0);
      chk("rst_ifack", 32'(arb_if.if_ack_o), 0);
      chk("rst_memack", 32'(arb_if.mem_ack_o), 0);
      chk("rst_err", 32'(arb_if.err_o), 0);
      chk("rst_addr", arb_if.bus_addr_o, 0);
      chk("rst_stall0", 32'(arb_if.stallreq_o), 0);
      arb_if.if_req_i  = 1;
      arb_if.if_addr_i = 32'h100;
      #1;
      chk("rst_stall1", 32'(arb_if.stallreq_o), 1);
      tick();
      chk("rst_nogrant", 32'(arb_if.bus_ce_o), 0);
      rst = 1;

      // Single fetch
      tick();
      chk("f_ce", 32'(arb_if.bus_ce_o), 1);
      chk("f_addr", arb_if.bus_addr_o, 32'h100);
      chk("f_we", 32'(arb_if.bus_we_o), 0);
      chk("f_sel", 32'(arb_if.bus_sel_o), 32'hF);
      chk("f_stall", 32'(arb_if.stallreq_o), 1);
      arb_if.bus_ack_i   = 1;
      arb_if.bus_rdata_i = 32'h34010001;
      tick();
      chk("f_ack", 32'(arb_if.if_ack_o), 1);
      chk("f_rdata", arb_if.if_rdata_o, 32'h34010001);
      chk("f_err", 32'(arb_if.err_o), 0);
      chk("f_ce_off", 32'(arb_if.bus_ce_o), 0);
      chk("f_stall_ack", 32'(arb_if.stallreq_o), 0);
      arb_if.if_req_i  = 0;
      // bus_ack held high in IDLE must do nothing
      tick();
      chk("f_ack_end", 32'(arb_if.if_ack_o), 0);
      chk("f_rdata_end", arb_if.if_rdata_o, 0);
      tick();
      chk("idle_ack_if", 32'(arb_if.if_ack_o), 0);
      chk("idle_ack_mem", 32'(arb_if.mem_ack_o), 0);
      chk("idle_ce", 32'(arb_if.bus_ce_o), 0);
      arb_if.bus_ack_i = 0;

      // Simultaneous requests: load first, fetch granted in the load ack cycle
      arb_if.if_req_i   = 1;
      arb_if.if_addr_i  = 32'h300;
      arb_if.mem_req_i  = 1;
      arb_if.mem_we_i   = 0;
      arb_if.mem_addr_i = 32'h200;
      arb_if.mem_sel_i  = 4'hF;
      tick();
      chk("s_ce", 32'(arb_if.bus_ce_o), 1);
      chk("s_addr_mem", arb_if.bus_addr_o, 32'h200);
      arb_if.bus_ack_i   = 1;
      arb_if.bus_rdata_i = 32'h11112222;
      tick();
      chk("s_memack", 32'(arb_if.mem_ack_o), 1);
      chk("s_memrdata", arb_if.mem_rdata_o, 32'h11112222);
      chk("s_ifack0", 32'(arb_if.if_ack_o), 0);
      chk("s_ce_gap", 32'(arb_if.bus_ce_o), 0);
      chk("s_stall", 32'(arb_if.stallreq_o), 1);
      arb_if.bus_ack_i = 0;
      // mem_req_i still high in its ack cycle: must not be re-granted
      tick();
      chk("s_ce2", 32'(arb_if.bus_ce_o), 1);
      chk("s_addr_if", arb_if.bus_addr_o, 32'h300);
      chk("s_we_if", 32'(arb_if.bus_we_o), 0);
      chk("s_memack_end", 32'(arb_if.mem_ack_o), 0);
      arb_if.mem_req_i   = 0;
      arb_if.bus_ack_i   = 1;
      arb_if.bus_rdata_i = 32'hCAFEF00D;
      tick();
      chk("s_ifack", 32'(arb_if.if_ack_o), 1);
      chk("s_ifrdata", arb_if.if_rdata_o, 32'hCAFEF00D);
      chk("s_memrdata0", arb_if.mem_rdata_o, 0);
      arb_if.if_req_i  = 0;
      arb_if.bus_ack_i = 0;
      tick();
      chk("s_idle", 32'(arb_if.bus_ce_o), 0);

      // Store with 3 wait cycles
      arb_if.mem_req_i   = 1;
      arb_if.mem_we_i    = 1;
      arb_if.mem_addr_i  = 32'h40;
      arb_if.mem_wdata_i = 32'hDEADBEEF;
      arb_if.mem_sel_i   = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("st_ce", 32'(arb_if.bus_ce_o), 1);
         chk("st_we", 32'(arb_if.bus_we_o), 1);
         chk("st_addr", arb_if.bus_addr_o, 32'h40);
         chk("st_wdata", arb_if.bus_wdata_o, 32'hDEADBEEF);
         chk("st_sel", 32'(arb_if.bus_sel_o), 32'h3);
         chk("st_noack", 32'(arb_if.mem_ack_o), 0);
         if (i == 3) begin
            arb_if.bus_ack_i   = 1;
            arb_if.bus_rdata_i = 32'hFFFFFFFF;
         end
      end
      tick();
      chk("st_ack", 32'(arb_if.mem_ack_o), 1);
      chk("st_rdata0", arb_if.mem_rdata_o, 0);
      chk("st_err", 32'(arb_if.err_o), 0);
      arb_if.mem_req_i = 0;
      arb_if.mem_we_i  = 0;
      arb_if.bus_ack_i = 0;
      tick();

      // Timeout on a fetch
      arb_if.if_req_i    = 1;
      arb_if.if_addr_i   = 32'h500;
      arb_if.bus_rdata_i = 32'h55AA55AA;
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("to_ce", 32'(arb_if.bus_ce_o), 1);
         chk("to_noack", 32'(arb_if.if_ack_o), 0);
      end
      tick();
      chk("to_ack", 32'(arb_if.if_ack_o), 1);
      chk("to_err", 32'(arb_if.err_o), 1);
      chk("to_rdata0", arb_if.if_rdata_o, 0);
      chk("to_ce_off", 32'(arb_if.bus_ce_o), 0);
      arb_if.if_req_i = 0;
      tick();
      chk("to_err_end", 32'(arb_if.err_o), 0);

      // Reset during a load
      arb_if.mem_req_i  = 1;
      arb_if.mem_we_i   = 0;
      arb_if.mem_addr_i = 32'h600;
      arb_if.mem_sel_i  = 4'hF;
      tick();
      chk("rm_ce", 32'(arb_if.bus_ce_o), 1);
      #2 rst = 0;
      #1;
      chk("rm_ce0", 32'(arb_if.bus_ce_o), 0);
      chk("rm_ack0", 32'(arb_if.mem_ack_o), 0);
      chk("rm_addr0", arb_if.bus_addr_o, 0);
      tick();
      chk("rm_hold", 32'(arb_if.bus_ce_o), 0);
      #3 rst = 1;
      tick();
      chk("rm_regrant", 32'(arb_if.bus_ce_o), 1);
      chk("rm_addr", arb_if.bus_addr_o, 32'h600);
      arb_if.bus_ack_i   = 1;
      arb_if.bus_rdata_i = 32'h0BADF00D;
      tick();
      chk("rm_ack", 32'(arb_if.mem_ack_o), 1);
      chk("rm_rdata", arb_if.mem_rdata_o, 32'h0BADF00D);
      arb_if.mem_req_i = 0;
      arb_if.bus_ack_i = 0;
      tick();

      // Back-to-back fetches, request held, memory always ready
      arb_if.if_req_i    = 1;
      arb_if.if_addr_i   = 32'h700;
      arb_if.bus_ack_i   = 1;
      arb_if.bus_rdata_i = 32'h13579BDF;
      for (int n = 0; n < 2; n++) begin
         tick();
         chk("bb_ce_x", 32'(arb_if.bus_ce_o), 1);
         chk("bb_ack_x", 32'(arb_if.if_ack_o), 0);
         chk("bb_stall_x", 32'(arb_if.stallreq_o), 1);
         tick();
         chk("bb_ce_a", 32'(arb_if.bus_ce_o), 0);
         chk("bb_ack_a", 32'(arb_if.if_ack_o), 1);
         chk("bb_stall_a", 32'(arb_if.stallreq_o), 0);
         tick();
         chk("bb_ce_i", 32'(arb_if.bus_ce_o), 0);
         chk("bb_ack_i", 32'(arb_if.if_ack_o), 0);
         chk("bb_stall_i", 32'(arb_if.stallreq_o), 1);
      end
      arb_if.if_req_i  = 0;
      arb_if.bus_ack_i = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the number of XFER cycles without bus_ack_i before a transfer is aborted (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req_i  input  1  instruction-fetch request; held high until if_ack_o.
REQ-005 SHALL have port if_addr_i  input  32  fetch byte address.
REQ-006 SHALL have port if_rdata_o  output  32  fetched instruction; valid while if_ack_o=1.
REQ-007 SHALL have port if_ack_o  output  1  one-cycle completion pulse for fetch.
REQ-008 SHALL have port mem_req_i  input  1  load/store request; held high until mem_ack_o.
REQ-009 SHALL have port mem_we_i  input  1  1=store, 0=load.
REQ-010 SHALL have port mem_addr_i  input  32  load/store byte address.
REQ-011 SHALL have port mem_wdata_i  input  32  store data.
REQ-012 SHALL have port mem_sel_i  input  4  byte enables.
REQ-013 SHALL have port mem_rdata_o  output  32  load data; valid while mem_ack_o=1.
REQ-014 SHALL have port mem_ack_o  output  1  one-cycle completion pulse for load/store.
REQ-015 SHALL have port bus_ce_o  output  1  shared-memory cycle enable.
REQ-016 SHALL have port bus_we_o  output  1  shared-memory write enable.
REQ-017 SHALL have port bus_addr_o  output  32  shared-memory address.
REQ-018 SHALL have port bus_wdata_o  output  32  shared-memory write data.
REQ-019 SHALL have port bus_sel_o  output  4  shared-memory byte enables.
REQ-020 SHALL have port bus_rdata_i  input  32  shared-memory read data.
REQ-021 SHALL have port bus_ack_i  input  1  shared-memory completion.
REQ-022 SHALL have port err_o  output  1  one-cycle pulse accompanying an ack caused by timeout.
REQ-023 SHALL have port stallreq_o  output  1  pipeline stall request to the stall controller.

Function
REQ-024 SHALL implement FSM with states IDLE, IF_XFER and MEM_XFER.
REQ-025 In IDLE, mem_req_i=1 SHALL win over if_req_i=1 (fixed priority) and the next state SHALL be MEM_XFER; otherwise if_req_i=1 SHALL give IF_XFER; otherwise the FSM SHALL stay in IDLE.
REQ-026 On grant, address, we, wdata and sel SHALL be registered, and bus_* outputs SHALL be driven from these registers for the whole XFER state.
REQ-027 For an IF grant, bus_we_o=0 and bus_sel_o=4'b1111.
REQ-028 bus_ce_o SHALL be 1 exactly while in IF_XFER or MEM_XFER.
REQ-029 In an XFER state with bus_ack_i=1, the FSM SHALL return to IDLE.
REQ-030 The owning ack_o SHALL pulse high for exactly the following cycle, with rdata_o = bus_rdata_i captured at that edge.
REQ-031 Store completions SHALL give mem_rdata_o=0.
REQ-032 Minimum latency SHALL be: request sampled in cycle N, bus_ce_o in N+1, ack_o in N+2 if bus_ack_i is high in N+1.
REQ-033 A requester's req_i that is high in the same cycle as its own ack_o SHALL be ignored for arbitration (request consumed).
REQ-034 The other requester SHALL be grantable in that same cycle.
REQ-035 A 4-bit wait counter SHALL clear on grant and increment each XFER cycle without bus_ack_i.
REQ-036 When the counter reaches TIMEOUT, the FSM SHALL go to IDLE and pulse the owning ack_o together with err_o, with rdata_o=0.
REQ-037 bus_ack_i SHALL be ignored in IDLE.
REQ-038 if_rdata_o and mem_rdata_o SHALL be 0 whenever their ack is 0.
REQ-039 stallreq_o SHALL be combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
REQ-040 Requests arriving during XFER SHALL wait; at most one transfer SHALL be outstanding.

Reset
REQ-041 rst=0 SHALL asynchronously force IDLE, counter=0, and all outputs 0 (except stallreq_o, which follows REQ-039), including mid-transfer.
REQ-042 After rst returns to 1, the first grant SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-043 Single fetch: if_req_i=1, if_addr_i=0x100, bus_ack_i=1 with bus_rdata_i=0x34010001 one cycle after bus_ce_o -> bus_addr_o=0x100, then if_ack_o=1 for one cycle with if_rdata_o=0x34010001.
REQ-044 Simultaneous requests: if_req_i=1 and mem_req_i=1 (load 0x200) in the same cycle -> MEM served first, then IF granted in the cycle mem_ack_o pulses; two bus_ce_o periods.
REQ-045 Store: mem_we_i=1, addr 0x40, wdata 0xDEADBEEF, sel 4'b0011, bus_ack_i after 3 wait cycles -> bus_we_o=1 with those values for 4 cycles, then mem_ack_o=1 with mem_rdata_o=0.
REQ-046 Timeout: TIMEOUT=15, bus_ack_i held 0 -> bus_ce_o high for 15 cycles, then if_ack_o=1, err_o=1, if_rdata_o=0.
REQ-047 Reset mid-transfer: rst=0 during MEM_XFER -> bus_ce_o=0 and mem_ack_o=0 immediately; after release with mem_req_i=1, a fresh grant follows.
REQ-048 Back-to-back fetches with if_req_i held high -> no duplicate grant in the ack cycle; stallreq_o=0 exactly in the ack cycles.
